// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: queue entry layout,
// FSM encoding and the boot PC.
package inst_fetch_ctrl_pkg;

    localparam int ENTRY_WIDTH = 68;

    localparam int INST_LSB   = 0;
    localparam int PC_LSB     = 32;
    localparam int EXC_ADEL   = 64;
    localparam int EXC_BUSERR = 65;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_ALIGN_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT       = 2'd2;

    // Builds one instruction queue entry; the top two bits are reserved zero.
    function automatic logic [ENTRY_WIDTH-1:0] make_entry(
        input logic        bus_err,
        input logic        adel,
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        logic [ENTRY_WIDTH-1:0] e;
        e                  = '0;
        e[INST_LSB +: 32]  = inst;
        e[PC_LSB +: 32]    = pc;
        e[EXC_ADEL]        = adel;
        e[EXC_BUSERR]      = bus_err;
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_pc_queue.sv
// PC tag FIFO: remembers the address of every live in-flight fetch so the
// in-order response can be tagged with it. Head is valid combinationally.
module fetch_pc_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch producer: sequential PC generation, in-order I-cache
// requests, credit-based writes into the instruction queue, redirect flushing.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int          FIFO_WIDTH      = ENTRY_WIDTH,
    parameter int          BUFFER_DEPTH    = 32,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = inst_fetch_ctrl_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_redirect_valid,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_ireq_valid,
    input  logic                  i_ireq_ready,
    output logic [31:0]           o_ireq_addr,
    input  logic                  i_iresp_valid,
    input  logic [31:0]           i_iresp_data,
    input  logic                  i_iresp_err,
    input  logic                  i_fifo_rd,
    output logic                  o_fifo_wr,
    output logic [FIFO_WIDTH-1:0] o_fifo_din,
    output logic                  o_fifo_flush
);

    localparam int CRW = $clog2(BUFFER_DEPTH);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(BUFFER_DEPTH - 1);

    logic [31:0]    r_pc;
    logic [CRW-1:0] r_credits;
    logic [OW-1:0]  r_outstanding;
    logic [OW-1:0]  r_drop_cnt;
    logic [1:0]     r_state;

    logic           w_run_ok;
    logic           w_issue_ok;
    logic           w_issue;
    logic           w_resp_live;
    logic           w_resp_drop;
    logic           w_align_wr;
    logic           w_consume;
    logic [OW:0]    w_inflight;
    logic [CRW-1:0] w_credits_next;
    logic [31:0]    w_head_pc;

    // Stale responses still occupy the I-cache pipeline, so they count toward the limit.
    assign w_run_ok    = !i_reset && !i_redirect_valid;
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_drop_cnt};
    assign w_issue_ok  = w_run_ok && (r_state == ST_RUN) && (r_pc[1:0] == 2'b00)
                         && (r_credits != '0) && (w_inflight < (OW+1)'(MAX_OUTSTANDING));
    assign w_issue     = w_issue_ok && i_ireq_ready;
    assign w_resp_live = w_run_ok && i_iresp_valid && (r_drop_cnt == '0);
    assign w_resp_drop = i_iresp_valid && (r_drop_cnt != '0);
    assign w_align_wr  = w_run_ok && (r_state == ST_ALIGN_WAIT) && (r_outstanding == '0)
                         && (r_drop_cnt == '0) && (r_credits != '0);
    assign w_consume   = w_issue || w_align_wr;

    assign o_ireq_valid = w_issue_ok;
    assign o_ireq_addr  = r_pc;
    assign o_fifo_flush = i_redirect_valid;
    assign o_fifo_wr    = w_resp_live || w_align_wr;
    assign o_fifo_din   = w_resp_live ? make_entry(i_iresp_err, 1'b0, w_head_pc, i_iresp_data)
                                      : make_entry(1'b0, 1'b1, r_pc, 32'h0);

    always_comb begin
        w_credits_next = r_credits;
        if (i_fifo_rd && !w_consume && (r_credits != CREDIT_MAX))
            w_credits_next = r_credits + 1'b1;
        else if (!i_fifo_rd && w_consume)
            w_credits_next = r_credits - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_pc          <= RESET_PC;
            r_credits     <= CREDIT_MAX;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_state       <= ST_RUN;
        end else if (i_redirect_valid) begin
            // Everything still in flight becomes stale; a response in this cycle retires one.
            r_pc          <= i_redirect_pc;
            r_credits     <= CREDIT_MAX;
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - OW'(i_iresp_valid);
            r_state       <= ST_RUN;
        end else begin
            if (w_issue) r_pc <= r_pc + 32'd4;
            r_credits     <= w_credits_next;
            r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_resp_live);
            r_drop_cnt    <= r_drop_cnt - OW'(w_resp_drop);
            case (r_state)
                ST_RUN:        if (r_pc[1:0] != 2'b00) r_state <= ST_ALIGN_WAIT;
                ST_ALIGN_WAIT: if (w_align_wr) r_state <= ST_HALT;
                default:       r_state <= ST_HALT;
            endcase
        end
    end

    fetch_pc_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_pc_queue (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_clear     (i_redirect_valid),
        .i_push      (w_issue),
        .i_push_data (r_pc),
        .i_pop       (w_resp_live),
        .o_head      (w_head_pc)
    );

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch-side producer for the 68-bit instruction queue FIFO. It generates sequential PCs, issues in-order fetch requests to the I-cache, and tags each response with its PC and exception flags. It writes the result into the FIFO using credit-based flow control, because the FIFO exposes only full/empty. It also handles branch/exception redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
FIFO_WIDTH, 68, entry width; fixed layout {2'b0, bus_err, adel, pc[31:0], inst[31:0]}
BUFFER_DEPTH, 32, downstream FIFO depth; usable capacity is BUFFER_DEPTH-1
MAX_OUTSTANDING, 4, maximum in-flight I-cache requests, stale ones included
RESET_PC, 32'hbfc00000, PC after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  flush-and-redirect pulse from branch/exception unit
redirect_pc  in  32  new fetch PC
ireq_valid  out  1  fetch request valid
ireq_ready  in  1  I-cache accepts request
ireq_addr  out  32  fetch address (word aligned)
iresp_valid  in  1  in-order response valid; always accepted
iresp_data  in  32  instruction word
iresp_err  in  1  bus/access error on the fetch
fifo_rd  in  1  downstream FIFO rd_en, tapped for credit return
fifo_wr  out  1  FIFO wr_en
fifo_din  out  FIFO_WIDTH  FIFO din
fifo_flush  out  1  ORed with reset at the FIFO's reset input

Behaviour:
- Reset values: pc=RESET_PC; credits=BUFFER_DEPTH-1; outstanding=0; drop_cnt=0; state=RUN; pc queue empty. Outputs ireq_valid, fifo_wr and fifo_flush are 0.
- fifo_flush = redirect_valid, combinational. The FIFO clears at the same edge.
- Issue condition: ireq_valid = state==RUN & pc[1:0]==0 & credits!=0 & (outstanding+drop_cnt)<MAX_OUTSTANDING & !redirect_valid.
- ireq_addr = pc. On handshake: pc+=4, credits-=1, outstanding+=1, pc pushed into the pc queue.
- Credits: +1 on fifo_rd unless redirect_valid. Simultaneous issue and fifo_rd leave credits unchanged. Credits never exceed BUFFER_DEPTH-1. Because a slot is reserved at issue, every response has FIFO space, so fifo_wr never coincides with full.
- Response handling:
  - iresp_valid with drop_cnt!=0: drop_cnt-=1, nothing written.
  - Otherwise: outstanding-=1, pc queue popped, fifo_wr=1, fifo_din={2'b0, iresp_err, 1'b0, head_pc, iresp_data}.
  - Latency: response to FIFO write is 0 cycles (combinational).
- Misaligned PC (pc[1:0]!=0) in RUN: no request is issued; state becomes ALIGN_WAIT.
- ALIGN_WAIT: once outstanding==0, drop_cnt==0 and credits!=0, write one entry {2'b0, 1'b0, 1'b1, pc, 32'h0}, credits-=1, state becomes HALT.
- HALT: no requests; the block waits for a redirect.
- Redirect, any state:
  - pc=redirect_pc; credits=BUFFER_DEPTH-1; pc queue cleared; state=RUN.
  - drop_cnt_next = drop_cnt + outstanding - (iresp_valid?1:0); outstanding=0.
  - fifo_wr and ireq_valid are forced 0 that cycle.
  - A response arriving in the redirect cycle is discarded.
- A redirect has priority over every other event in the same cycle.
- A reset mid-burst behaves like a redirect to RESET_PC, except drop_cnt=0. The I-cache is reset together with this block, so no stale responses remain.
- Counter widths: credits $clog2(BUFFER_DEPTH) bits; outstanding and drop_cnt $clog2(MAX_OUTSTANDING+1) bits.
- Assertions for the bench:
  - A response never arrives while outstanding==0 and drop_cnt==0.
  - Credits never underflow.
  - fifo_wr never coincides with full.

Decomposition:
- Shared package: entry field offsets (INST_LSB=0, PC_LSB=32, EXC_ADEL=64, EXC_BUSERR=65), the state encoding (RUN, ALIGN_WAIT, HALT), and RESET_PC.
- Sub-module fetch_pc_queue: PC tag FIFO, depth MAX_OUTSTANDING, 32 bits wide, with push, pop, clear, and a head output that is valid combinationally.

Test Plan:
- Reset, ireq_ready=1, one-cycle response latency, no fifo_rd -> exactly 31 requests issued, addresses 0xbfc00000..0xbfc00078. FIFO entry 0 = {4'b0, 0xbfc00000, data0}. Then ireq_valid=0 until a fifo_rd occurs.
- Saturated FIFO; assert fifo_rd for one cycle -> exactly one new request, at 0xbfc0007c. Credits return to 0.
- Four requests in flight; redirect to 0x80001000 while a response arrives the same cycle -> fifo_flush=1, drop_cnt=3. The next three responses are not written; the next request is 0x80001000 and its response is tagged pc=0x80001000.
- Redirect to 0x80000002 -> no ireq issued. After drain, a single entry {2'b01, 0x80000002, 0} (bus_err=0, adel=1) is written; then idle until the next redirect.
- Response at 0xbfc00010 with iresp_err=1 -> entry bits[65:64]=2'b10, pc=0xbfc00010; fetching continues sequentially.
- Simultaneous issue and fifo_rd every cycle for 100 cycles with ready toggling randomly -> credits stable. Entries arrive in PC order with no gaps and no duplicates.
